// File: rtl/lag_tracker.sv
// lag_tracker: supervises the microphone-array sub-system, clamps and
// moving-average filters each reported lag, and maps the filtered lag to a
// horizontal pixel coordinate for the camera overlay.
// Optional feature macro: LAG_TRACKER_MEDIAN3_EN. When it is defined, a 3-tap
// median of the last three clamped captures feeds the averaging window
// instead of the raw clamped capture.
module lag_tracker #(
  parameter int LAGNUM   = 16,
  parameter int AVG_LOG2 = 2,
  parameter int X_CENTER = 320,
  parameter int X_STEP   = 20,
  parameter int X_MAX    = 639,
  parameter int TIMEOUT  = 6000000
) (
  input  logic              clk_60MHz,
  input  logic              rst_n,
  input  logic              run,
  input  logic              subsys_done,
  input  logic signed [5:0] lag_diff,
  output logic              subsys_start,
  output logic signed [5:0] lag_avg,
  output logic [10:0]       pos_x,
  output logic              pos_valid,
  output logic              timeout_err
);

  localparam int D  = 1 << AVG_LOG2;
  localparam int SW = 6 + AVG_LOG2;                  // running sum width
  localparam int PW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1; // write pointer width
  localparam int CW = AVG_LOG2 + 1;                  // fill count width
  localparam int TW = $clog2(TIMEOUT + 1);           // timeout timer width

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    WAIT   = 3'd2,
    ACCUM  = 3'd3,
    OUTPUT = 3'd4
  } state_t;

  state_t                 state_r;
  state_t                 state_next;
  logic                   capture_s;
  logic                   time_hit_s;
  logic [TW-1:0]          timer_r;
  logic signed [5:0]      clamped_s;
  logic signed [5:0]      sample_next_s;
  logic signed [5:0]      sample_r;
  logic signed [5:0]      win_r [D];
  logic signed [SW-1:0]   sum_r;
  logic signed [SW-1:0]   old_ext_s;
  logic signed [SW-1:0]   new_ext_s;
  logic [PW-1:0]          wptr_r;
  logic [CW-1:0]          fill_r;
  logic signed [5:0]      avg_s;
  logic signed [31:0]     pos_s;
  logic [10:0]            pos_clamped_s;

  // Saturate a raw upstream lag to the legal range [-LAGNUM, +LAGNUM].
  function automatic logic signed [5:0] clamp_lag(input logic signed [5:0] v);
    logic signed [5:0] hi;
    logic signed [5:0] lo;
    hi = 6'(LAGNUM);
    lo = 6'(-LAGNUM);
    if (v > hi) begin
      clamp_lag = hi;
    end else if (v < lo) begin
      clamp_lag = lo;
    end else begin
      clamp_lag = v;
    end
  endfunction

`ifdef LAG_TRACKER_MEDIAN3_EN
  logic signed [5:0] hist1_r;
  logic signed [5:0] hist2_r;

  // Median of three signed values.
  function automatic logic signed [5:0] med3(input logic signed [5:0] a,
                                             input logic signed [5:0] b,
                                             input logic signed [5:0] c);
    if (((a >= b) && (a <= c)) || ((a <= b) && (a >= c))) begin
      med3 = a;
    end else if (((b >= a) && (b <= c)) || ((b <= a) && (b >= c))) begin
      med3 = b;
    end else begin
      med3 = c;
    end
  endfunction

  // Shift the capture history so the median always sees the last three captures.
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      hist1_r <= 6'sd0;
      hist2_r <= 6'sd0;
    end else if (capture_s) begin
      hist1_r <= clamped_s;
      hist2_r <= hist1_r;
    end
  end

  // Clamp the incoming lag and take the median with the two previous captures.
  always_comb begin
    clamped_s     = clamp_lag(lag_diff);
    sample_next_s = med3(clamped_s, hist1_r, hist2_r);
  end
`else
  // Clamp the incoming lag; the clamped value feeds the window directly.
  always_comb begin
    clamped_s     = clamp_lag(lag_diff);
    sample_next_s = clamped_s;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic; done has priority over the timeout in WAIT.
  always_comb begin
    state_next = state_r;
    capture_s  = 1'b0;
    time_hit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (run) begin
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (subsys_done) begin
          capture_s  = 1'b1;
          state_next = ACCUM;
        end else if (timer_r == TW'(TIMEOUT - 1)) begin
          time_hit_s = 1'b1;
          state_next = run ? START : IDLE;
        end else begin
          state_next = WAIT;
        end
      end
      ACCUM: begin
        state_next = OUTPUT;
      end
      OUTPUT: begin
        state_next = run ? START : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Timeout timer: cleared on each launch, counts while waiting for done.
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= {TW{1'b0}};
    end else if (state_r == START) begin
      timer_r <= {TW{1'b0}};
    end else if (state_r == WAIT) begin
      timer_r <= timer_r + TW'(1);
    end
  end

  // Latch the (clamped, optionally median-filtered) sample with done.
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      sample_r <= 6'sd0;
    end else if (capture_s) begin
      sample_r <= sample_next_s;
    end
  end

  // Sign-extend the evicted and incoming samples to the running-sum width.
  always_comb begin
    old_ext_s = SW'(win_r[wptr_r]);
    new_ext_s = SW'(sample_r);
  end

  // Moving-average window: replace the oldest entry and update the running sum.
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) begin
        win_r[i] <= 6'sd0;
      end
      sum_r  <= {SW{1'b0}};
      wptr_r <= {PW{1'b0}};
      fill_r <= {CW{1'b0}};
    end else if (state_r == ACCUM) begin
      win_r[wptr_r] <= sample_r;
      sum_r         <= sum_r - old_ext_s + new_ext_s;
      if (wptr_r == PW'(D - 1)) begin
        wptr_r <= {PW{1'b0}};
      end else begin
        wptr_r <= wptr_r + PW'(1);
      end
      if (fill_r != CW'(D)) begin
        fill_r <= fill_r + CW'(1);
      end
    end
  end

  // Floor-divide the sum by the window depth and map it to a clamped pixel x.
  always_comb begin
    avg_s = 6'(sum_r >>> AVG_LOG2);
    pos_s = 32'(X_CENTER) + (32'(avg_s) * 32'(X_STEP));
    if (pos_s < 32'sd0) begin
      pos_clamped_s = 11'd0;
    end else if (pos_s > 32'(X_MAX)) begin
      pos_clamped_s = 11'(X_MAX);
    end else begin
      pos_clamped_s = pos_s[10:0];
    end
  end

  // Launch pulse is high for exactly the cycle the FSM spends in START.
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      subsys_start <= 1'b0;
    end else if (state_next == START) begin
      subsys_start <= 1'b1;
    end else begin
      subsys_start <= 1'b0;
    end
  end

  // Result registers: updated in OUTPUT, held otherwise; valid only once primed.
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      lag_avg   <= 6'sd0;
      pos_x     <= 11'(X_CENTER);
      pos_valid <= 1'b0;
    end else if (state_r == OUTPUT) begin
      lag_avg   <= avg_s;
      pos_x     <= pos_clamped_s;
      pos_valid <= (fill_r == CW'(D));
    end else begin
      pos_valid <= 1'b0;
    end
  end

  // Sticky timeout flag: set on a missed done, cleared by the next result.
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else if (time_hit_s) begin
      timeout_err <= 1'b1;
    end else if (state_r == OUTPUT) begin
      timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lag_tracker.sv
// Self-checking bench for lag_tracker (short TIMEOUT). Expected averages come
// from a reference model that recomputes the window sum from scratch and
// floor-divides; results are queued at done time and compared when pos_valid
// pulses.
`timescale 1ns/1ps
module tb_lag_tracker;

  localparam int TO    = 40;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              run;
  logic              subsys_done;
  logic signed [5:0] lag_diff;
  logic              subsys_start;
  logic signed [5:0] lag_avg;
  logic [10:0]       pos_x;
  logic              pos_valid;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;

  typedef struct {int avg; int pos;} exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int mwin[DEPTH];
  int mptr;
  int mfill;
  int mh1;
  int mh2;

  always #5 clk = ~clk;

  lag_tracker #(.TIMEOUT(TO)) dut (
    .clk_60MHz   (clk),
    .rst_n       (rst_n),
    .run         (run),
    .subsys_done (subsys_done),
    .lag_diff    (lag_diff),
    .subsys_start(subsys_start),
    .lag_avg     (lag_avg),
    .pos_x       (pos_x),
    .pos_valid   (pos_valid),
    .timeout_err (timeout_err)
  );

  // Scoreboard: every pos_valid pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && pos_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: pos_valid with lag_avg=%0d pos_x=%0d, required no result", lag_avg, pos_x);
      end else begin
        mon_e = sb.pop_front();
        if (int'(lag_avg) !== mon_e.avg || int'(pos_x) !== mon_e.pos) begin
          errors++;
          $display("FAIL sb_result: lag_avg=%0d pos_x=%0d, required lag_avg=%0d pos_x=%0d",
                   lag_avg, pos_x, mon_e.avg, mon_e.pos);
        end
      end
    end
  end

  task automatic model_reset;
    for (int i = 0; i < DEPTH; i++) mwin[i] = 0;
    mptr = 0; mfill = 0; mh1 = 0; mh2 = 0;
  endtask

  function automatic int med3_m(input int a, input int b, input int c);
    int lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return (hi < c) ? hi : ((lo > c) ? lo : c);
  endfunction

  // Reference model: returns whether a result is due and its expected values.
  task automatic model_push(input int lag, output bit v, output int ea, output int ep);
    logic signed [5:0] l6;
    int c, smp, sum;
    l6 = 6'(lag);
    c = int'(l6);
    if (c > 16) c = 16;
    else if (c < -16) c = -16;
`ifdef LAG_TRACKER_MEDIAN3_EN
    smp = med3_m(c, mh1, mh2);
    mh2 = mh1;
    mh1 = c;
`else
    smp = c;
`endif
    mwin[mptr] = smp;
    mptr = (mptr + 1) % DEPTH;
    if (mfill < DEPTH) mfill++;
    sum = 0;
    for (int i = 0; i < DEPTH; i++) sum += mwin[i];
    ea = sum / DEPTH;
    if ((sum % DEPTH) != 0 && sum < 0) ea = ea - 1;
    ep = 320 + ea * 20;
    if (ep < 0) ep = 0;
    else if (ep > 639) ep = 639;
    v = (mfill == DEPTH);
  endtask

  // One measurement: wait for the launch, wait 'pre' WAIT cycles, answer with lag.
  task automatic do_measure(input int lag, input int pre, input bit drop, input bit terr_mid);
    int n;
    bit v;
    int ea, ep;
    n = 0;
    while (subsys_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (subsys_start !== 1'b1) begin
      errors++;
      $display("FAIL start_wait: subsys_start=%b, required 1 within 200 cycles", subsys_start);
    end
    @(negedge clk);
    if (drop) run = 1'b0;
    repeat (pre) @(negedge clk);
    lag_diff = 6'(lag);
    subsys_done = 1'b1;
    model_push(lag, v, ea, ep);
    if (v) sb.push_back('{avg: ea, pos: ep});
    @(negedge clk);
    subsys_done = 1'b0;
    lag_diff = 6'($urandom_range(0, 63));
    checks++;
    if (subsys_start !== 1'b0) begin
      errors++;
      $display("FAIL start_mid: subsys_start=%b, required 0", subsys_start);
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== terr_mid) begin
      errors++;
      $display("FAIL terr_mid: timeout_err=%b, required %b", timeout_err, terr_mid);
    end
    @(negedge clk);
    checks++;
    if (pos_valid !== v || subsys_start !== run || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL latency: pos_valid=%b subsys_start=%b timeout_err=%b, required %b %b 0",
               pos_valid, subsys_start, timeout_err, v, run);
    end
  endtask

  task automatic test_reset;
    bit seen;
    rst_n = 1'b0; run = 1'b0; subsys_done = 1'b0; lag_diff = 6'sd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (subsys_start === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_start: subsys_start seen=%b, required 0", seen); end
    checks++;
    if (pos_x !== 11'd320) begin errors++; $display("FAIL rst_pos: pos_x=%0d, required 320", pos_x); end
    checks++;
    if (lag_avg !== 6'sd0) begin errors++; $display("FAIL rst_avg: lag_avg=%0d, required 0", lag_avg); end
    checks++;
    if (pos_valid !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags: pos_valid=%b timeout_err=%b, required 0 0", pos_valid, timeout_err);
    end
  endtask

  task automatic test_prime;
    run = 1'b1;
    for (int i = 0; i < 4; i++) do_measure(4, i, 1'b0, 1'b0);
`ifndef LAG_TRACKER_MEDIAN3_EN
    checks++;
    if (lag_avg !== 6'sd4 || pos_x !== 11'd400) begin
      errors++;
      $display("FAIL prime_hold: lag_avg=%0d pos_x=%0d, required 4 400", lag_avg, pos_x);
    end
`endif
  endtask

  task automatic test_floor_clamp;
    int lags[8] = '{-3, -3, -3, -2, -17, -17, -17, -17};
    for (int i = 0; i < 8; i++) do_measure(lags[i], 0, 1'b0, 1'b0);
    checks++;
    if (pos_x !== 11'd0 || lag_avg !== -6'sd16) begin
      errors++;
      $display("FAIL low_clamp: lag_avg=%0d pos_x=%0d, required -16 0", lag_avg, pos_x);
    end
  endtask

  task automatic test_upper_clamp;
    for (int i = 0; i < 4; i++) do_measure(25, 1, 1'b0, 1'b0);
    checks++;
    if (pos_x !== 11'd639 || lag_avg !== 6'sd16) begin
      errors++;
      $display("FAIL high_clamp: lag_avg=%0d pos_x=%0d, required 16 639", lag_avg, pos_x);
    end
  endtask

  task automatic test_timeout;
    int n;
    n = 0;
    while (subsys_start !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (timeout_err !== 1'b1 && n < TO + 20) begin @(negedge clk); n++; end
    checks++;
    if (n !== TO + 1) begin errors++; $display("FAIL timeout_lat: cycles=%0d, required %0d", n, TO + 1); end
    checks++;
    if (subsys_start !== 1'b1) begin
      errors++;
      $display("FAIL timeout_restart: subsys_start=%b, required 1", subsys_start);
    end
    do_measure(7, 2, 1'b0, 1'b1);
  endtask

  task automatic test_midop_reset;
    int n;
    n = 0;
    while (subsys_start !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (pos_x !== 11'd320 || lag_avg !== 6'sd0 || subsys_start !== 1'b0 || pos_valid !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL midop_rst: pos_x=%0d lag_avg=%0d start=%b valid=%b terr=%b, required 320 0 0 0 0",
               pos_x, lag_avg, subsys_start, pos_valid, timeout_err);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) do_measure(-8, 0, 1'b0, 1'b0);
  endtask

  task automatic test_run_drop;
    bit seen;
    do_measure(5, 3, 1'b1, 1'b0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (subsys_start === 1'b1) seen = 1'b1;
    end
    lag_diff = 6'sd31;
    subsys_done = 1'b1;
    @(negedge clk);
    subsys_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (subsys_start === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL run_drop: subsys_start seen=%b, required 0", seen); end
  endtask

`ifdef LAG_TRACKER_MEDIAN3_EN
  task automatic test_median;
    int lags[7] = '{2, 2, 2, 2, 2, 15, 2};
    run = 1'b1;
    for (int i = 0; i < 7; i++) do_measure(lags[i], 0, 1'b0, 1'b0);
    checks++;
    if (lag_avg !== 6'sd2) begin errors++; $display("FAIL median: lag_avg=%0d, required 2", lag_avg); end
  endtask
`endif

  initial begin
    test_reset();
    test_prime();
    test_floor_clamp();
    test_upper_clamp();
    test_timeout();
    test_midop_reset();
    test_run_drop();
`ifdef LAG_TRACKER_MEDIAN3_EN
    test_median();
    run = 1'b0;
`endif
    repeat (10) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d results outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
